byte_data_memory: RTL and testbench

BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_lane_ram.sv | 27 ++
 rtl/byte_data_memory.sv | 216 +++++++++++++++++++++
 tb/tb_byte_data_memory.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory: access size
// encodings, controller state encoding and default geometry.
package dmem_pkg;

    localparam int DMEM_DATA_W_DEF      = 32;
    localparam int DMEM_DEPTH_BYTES_DEF = 1024;

    // size_i encodings
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    // Controller states; BEAT2 is only reachable in misaligned-capable builds
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT2 = 2'b01,
        RESP  = 2'b10
    } dmem_state_e;

    // Number of bytes touched by an access of the given size
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// Byte-lane storage array: ROWS rows of LANES bytes, one write enable per
// lane and a combinational row read port sharing the row address.
module dmem_lane_ram #(
    parameter int LANES = 4,
    parameter int ROWS  = 256
) (
    input  logic                     clk_i,
    input  logic [LANES-1:0]         we_i,
    input  logic [$clog2(ROWS)-1:0]  addr_i,
    input  logic [8*LANES-1:0]       wdata_i,
    output logic [8*LANES-1:0]       rdata_o
);

    // NOTE: storage is never reset; it starts at zero and keeps its contents across rst_i.
    logic [LANES-1:0][7:0] mem_q [ROWS] = '{default: '0};

    // Write only the enabled lanes of the addressed row
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < LANES; l++) begin
            // NOTE: non-blocking assignment for all clocked state so every reader sees pre-edge values.
            if (we_i[l]) mem_q[addr_i][l] <= wdata_i[8*l +: 8];
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressable data memory with byte/half/word/dword loads and stores,
// sign/zero extension and range/size fault reporting.
// Build option: define DMEM_MISALIGN_EN to split row-crossing accesses over
// two beats; otherwise any access not naturally aligned to its size faults.
module byte_data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_W      = DMEM_DATA_W_DEF,
    parameter int DEPTH_BYTES = DMEM_DEPTH_BYTES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    output logic              ready_o,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o
);

    localparam int LANES  = DATA_W / 8;
    localparam int ROWS   = DEPTH_BYTES / LANES;
    localparam int LANE_W = $clog2(LANES);
    localparam int ROW_W  = $clog2(ROWS);
`ifdef DMEM_MISALIGN_EN
    localparam int SPAN   = 2;   // an access may touch two adjacent rows
`else
    localparam int SPAN   = 1;
`endif

    dmem_state_e              state_q;
    logic                     err_q;
    logic [DATA_W-1:0]        data_q;

    logic                     accept;
    logic [LANE_W-1:0]        off;
    logic [ROW_W-1:0]         row;
    logic [3:0]               nbytes;
    logic [32:0]              last_addr;
    logic                     fault;
    logic [SPAN*LANES-1:0]    mask_w;
    logic [SPAN*DATA_W-1:0]   data_w;
    logic [SPAN*DATA_W-1:0]   rd_wide;
    logic [DATA_W-1:0]        load_data;
    logic [LANES-1:0]         ram_we;
    logic [ROW_W-1:0]         ram_addr;
    logic [DATA_W-1:0]        ram_wdata;
    logic [DATA_W-1:0]        ram_rdata;

`ifdef DMEM_MISALIGN_EN
    logic                     crossing;
    logic [ROW_W-1:0]         row_q;
    logic [LANE_W-1:0]        off_q;
    logic [1:0]               size_q;
    logic                     uns_q;
    logic                     we_q;
    logic [LANES-1:0]         hi_mask_q;
    logic [DATA_W-1:0]        hi_data_q;
    logic [DATA_W-1:0]        lo_q;
`endif

    // Pick the accessed bytes out of one or two rows, then extend to DATA_W
    function automatic logic [DATA_W-1:0] assemble(input logic [SPAN*DATA_W-1:0] wide,
                                                   input logic [LANE_W-1:0]      boff,
                                                   input logic [1:0]             size,
                                                   input logic                   uns);
        logic [DATA_W-1:0] res;
        logic              sign;
        int                n;
        int                msb_byte;
        n = int'(size_bytes(size));
        if (n > LANES) n = LANES;   // only reachable on faulted accesses
        msb_byte = (int'(boff) + n - 1) % (SPAN * LANES);
        sign = ~uns & wide[8*msb_byte + 7];
        res = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k < n) res[8*k +: 8] = wide[8*((int'(boff) + k) % (SPAN * LANES)) +: 8];
            else       res[8*k +: 8] = {8{sign}};
        end
        return res;
    endfunction

    assign ready_o   = (state_q == IDLE);
    assign rvalid_o  = (state_q == RESP);
    assign err_o     = rvalid_o & err_q;
    assign data_o    = data_q;

    assign accept    = req_i && ready_o;
    assign off       = addr_i[LANE_W-1:0];
    assign row       = addr_i[LANE_W +: ROW_W];
    assign nbytes    = size_bytes(size_i);
    assign last_addr = {1'b0, addr_i} + {29'b0, nbytes} - 33'd1;

    // Fault decode: out of range, unsupported size, or (single-beat build) misaligned
    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        fault = (last_addr >= 33'(DEPTH_BYTES));
        if (size_i == SZ_DWORD && DATA_W == 32) fault = 1'b1;
`ifdef DMEM_MISALIGN_EN
        // misaligned accesses are legal and handled in two beats
`else
        if ((addr_i[3:0] & (nbytes - 4'd1)) != 4'd0) fault = 1'b1;
`endif
    end

    // Shift store data and lane mask into position across the spanned rows
    always_comb begin
        mask_w = '0;
        data_w = '0;
        for (int i = 0; i < SPAN * LANES; i++) begin
            if (i >= int'(off) && i < int'(off) + int'(nbytes) && (i - int'(off)) < LANES) begin
                mask_w[i]         = 1'b1;
                data_w[8*i +: 8]  = data_i[8*(i - int'(off)) +: 8];
            end
        end
    end

`ifdef DMEM_MISALIGN_EN
    assign crossing  = ({1'b0, 4'(off)} + {1'b0, nbytes}) > 5'(LANES);
    assign rd_wide   = (state_q == BEAT2) ? {ram_rdata, lo_q} : {{DATA_W{1'b0}}, ram_rdata};
    assign load_data = (state_q == BEAT2) ? assemble(rd_wide, off_q, size_q, uns_q)
                                          : assemble(rd_wide, off, size_i, unsigned_i);
`else
    assign rd_wide   = ram_rdata;
    assign load_data = assemble(rd_wide, off, size_i, unsigned_i);
`endif

    // RAM port steering: accepted request row in IDLE, following row in BEAT2
    always_comb begin
        ram_addr  = row;
        ram_we    = '0;
        ram_wdata = data_w[DATA_W-1:0];
        if (state_q == IDLE) begin
            if (accept && we_i && !fault) ram_we = mask_w[LANES-1:0];
        end
`ifdef DMEM_MISALIGN_EN
        else if (state_q == BEAT2) begin
            ram_addr  = row_q + ROW_W'(1);
            ram_we    = we_q ? hi_mask_q : '0;
            ram_wdata = hi_data_q;
        end
`endif
    end

    dmem_lane_ram #(
        .LANES (LANES),
        .ROWS  (ROWS)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Controller: accept, optional second beat, one-cycle response
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            err_q     <= 1'b0;
            data_q    <= '0;
`ifdef DMEM_MISALIGN_EN
            row_q     <= '0;
            off_q     <= '0;
            size_q    <= SZ_BYTE;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            hi_mask_q <= '0;
            hi_data_q <= '0;
            lo_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        err_q <= fault;
                        if (fault) begin
                            data_q  <= '0;
                            state_q <= RESP;
                        end
`ifdef DMEM_MISALIGN_EN
                        else if (crossing) begin
                            row_q     <= row;
                            off_q     <= off;
                            size_q    <= size_i;
                            uns_q     <= unsigned_i;
                            we_q      <= we_i;
                            hi_mask_q <= mask_w[SPAN*LANES-1:LANES];
                            hi_data_q <= data_w[SPAN*DATA_W-1:DATA_W];
                            lo_q      <= ram_rdata;
                            state_q   <= BEAT2;
                        end
`endif
                        else begin
                            if (!we_i) data_q <= load_data;
                            state_q <= RESP;
                        end
                    end
                end
`ifdef DMEM_MISALIGN_EN
                BEAT2: begin
                    if (!we_q) data_q <= load_data;
                    state_q <= RESP;
                end
`endif
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_data_memory.sv
// Self-checking bench for byte_data_memory (DATA_W=32, DEPTH_BYTES=1024).
// Expectations follow DMEM_MISALIGN_EN when the bundle is built with it.
module tb_byte_data_memory;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        ready_o;
    logic        we_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        rvalid_o;
    logic [31:0] data_o;
    logic        err_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
        logic        check_data;
        int          id;
    } exp_t;

    vec_t vecs[18];
    exp_t exp_q[$];
    exp_t mon_e;

    byte_data_memory #(
        .DATA_W      (32),
        .DEPTH_BYTES (1024)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .ready_o    (ready_o),
        .we_i       (we_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .rvalid_o   (rvalid_o),
        .data_o     (data_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string what, input int id, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s #%0d: got %h expected %h", what, id, act, exp);
        end
    endtask

    // Scoreboard: every response is matched against the oldest pending expectation
    always @(negedge clk) begin
        if (rvalid_o) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rvalid: got rvalid_o=1 expected 0 at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("err", mon_e.id, 64'(err_o), 64'(mon_e.err));
                if (mon_e.check_data) check("data", mon_e.id, 64'(data_o), 64'(mon_e.data));
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_data,
                         input int exp_lat, input int id);
        int   lat;
        int   low;
        exp_t e;
        @(negedge clk);
        for (int w = 0; w < 8 && !ready_o; w++) @(negedge clk);
        req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns; addr_i = addr; data_i = wdata;
        e.err = exp_err;
        e.data = exp_err ? 32'h0 : exp_data;
        e.check_data = !we || exp_err;
        e.id = id;
        exp_q.push_back(e);
        @(posedge clk);
        #1 req_i = 1'b0;
        lat = 0;
        low = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (!ready_o) low++;
            if (rvalid_o) begin
                lat = c;
                break;
            end
        end
        check("latency", id, 64'(lat), 64'(exp_lat));
        check("ready_low", id, 64'(low), 64'(exp_lat));
        if (lat == 0) exp_q.delete();
    endtask

    initial begin
        logic [31:0] last_data;

        vecs[0]  = '{1'b1, SZ_WORD,  1'b0, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0,        1};
        vecs[1]  = '{1'b0, SZ_WORD,  1'b1, 32'h010, 32'h0,        1'b0, 32'hDEADBEEF, 1};
        vecs[2]  = '{1'b0, SZ_BYTE,  1'b0, 32'h013, 32'h0,        1'b0, 32'hFFFFFFDE, 1};
        vecs[3]  = '{1'b0, SZ_BYTE,  1'b1, 32'h013, 32'h0,        1'b0, 32'h000000DE, 1};
        vecs[4]  = '{1'b0, SZ_HALF,  1'b0, 32'h010, 32'h0,        1'b0, 32'hFFFFBEEF, 1};
        vecs[5]  = '{1'b0, SZ_HALF,  1'b1, 32'h012, 32'h0,        1'b0, 32'h0000DEAD, 1};
        vecs[6]  = '{1'b1, SZ_BYTE,  1'b0, 32'h011, 32'hFFFFFF5A, 1'b0, 32'h0,        1};
        vecs[7]  = '{1'b0, SZ_WORD,  1'b0, 32'h010, 32'h0,        1'b0, 32'hDEAD5AEF, 1};
        vecs[8]  = '{1'b1, SZ_HALF,  1'b0, 32'h012, 32'hAAAA1234, 1'b0, 32'h0,        1};
        vecs[9]  = '{1'b0, SZ_WORD,  1'b0, 32'h010, 32'h0,        1'b0, 32'h12345AEF, 1};
        vecs[10] = '{1'b0, SZ_WORD,  1'b0, 32'h3FE, 32'h0,        1'b1, 32'h0,        1};
        vecs[11] = '{1'b1, SZ_WORD,  1'b0, 32'h3FC, 32'hCAFEF00D, 1'b0, 32'h0,        1};
        vecs[12] = '{1'b0, SZ_WORD,  1'b1, 32'h3FC, 32'h0,        1'b0, 32'hCAFEF00D, 1};
        vecs[13] = '{1'b0, SZ_BYTE,  1'b0, 32'h3FF, 32'h0,        1'b0, 32'hFFFFFFCA, 1};
        vecs[14] = '{1'b0, SZ_DWORD, 1'b0, 32'h020, 32'h0,        1'b1, 32'h0,        1};
        vecs[15] = '{1'b1, SZ_WORD,  1'b0, 32'h400, 32'h12345678, 1'b1, 32'h0,        1};
        vecs[16] = '{1'b0, SZ_HALF,  1'b1, 32'h3FF, 32'h0,        1'b1, 32'h0,        1};
        vecs[17] = '{1'b0, SZ_BYTE,  1'b1, 32'h044, 32'h0,        1'b0, 32'h0,        1};

        req_i = 1'b0; we_i = 1'b0; size_i = SZ_BYTE; unsigned_i = 1'b0;
        addr_i = '0; data_i = '0;
        rst_i = 1'b1;
        #1 rst_i = 1'b0;
        @(posedge clk);
        #1;
        check("reset_ready",  0, 64'(ready_o),  64'd1);
        check("reset_rvalid", 0, 64'(rvalid_o), 64'd0);
        check("reset_err",    0, 64'(err_o),    64'd0);
        check("reset_data",   0, 64'(data_o),   64'd0);
        @(negedge clk);
        rst_i = 1'b1;

        // Table-driven single accesses
        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                  vecs[i].exp_err, vecs[i].exp_data, vecs[i].exp_lat, i);
        end

        // Misaligned word store straddling rows 0x0C and 0x10
        issue(1'b1, SZ_WORD, 1'b0, 32'h0C, 32'h0, 1'b0, 32'h0, 1, 100);
        issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1, 101);
`ifdef DMEM_MISALIGN_EN
        issue(1'b1, SZ_WORD, 1'b0, 32'h0E, 32'h11223344, 1'b0, 32'h0,        2, 102);
        issue(1'b0, SZ_WORD, 1'b1, 32'h0C, 32'h0,        1'b0, 32'h33440000, 1, 103);
        issue(1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0,        1'b0, 32'h00001122, 1, 104);
        issue(1'b0, SZ_WORD, 1'b1, 32'h0E, 32'h0,        1'b0, 32'h11223344, 2, 105);
        issue(1'b0, SZ_HALF, 1'b0, 32'h0F, 32'h0,        1'b0, 32'h00002233, 2, 106);
        last_data = 32'h00002233;
`else
        issue(1'b1, SZ_WORD, 1'b0, 32'h0E, 32'h11223344, 1'b1, 32'h0,        1, 102);
        issue(1'b0, SZ_WORD, 1'b1, 32'h0C, 32'h0,        1'b0, 32'h0,        1, 103);
        issue(1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0,        1'b0, 32'h0,        1, 104);
        issue(1'b0, SZ_WORD, 1'b1, 32'h0E, 32'h0,        1'b1, 32'h0,        1, 105);
        issue(1'b0, SZ_HALF, 1'b1, 32'h11, 32'h0,        1'b1, 32'h0,        1, 106);
        last_data = 32'h0;
`endif

        // data_o holds between responses
        @(negedge clk);
        @(negedge clk);
        check("hold_rvalid", 107, 64'(rvalid_o), 64'd0);
        check("hold_data",   107, 64'(data_o),   64'(last_data));

        // Request held high while busy must not be taken
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; size_i = SZ_WORD; unsigned_i = 1'b1; addr_i = 32'h3FC; data_i = '0;
        exp_q.push_back('{1'b0, 32'hCAFEF00D, 1'b1, 110});
        @(posedge clk);
        #1 we_i = 1'b1; addr_i = 32'h40; data_i = 32'h99;
        @(negedge clk);
        check("busy_ready", 110, 64'(ready_o), 64'd0);
        @(posedge clk);
        #1 req_i = 1'b0;
        repeat (2) @(negedge clk);
        issue(1'b0, SZ_WORD, 1'b1, 32'h40, 32'h0, 1'b0, 32'h0, 1, 111);

`ifdef DMEM_MISALIGN_EN
        // Reset during the second beat of a row-crossing store
        issue(1'b1, SZ_WORD, 1'b0, 32'h1C, 32'hFFFFFFFF, 1'b0, 32'h0, 1, 120);
        issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'hFFFFFFFF, 1'b0, 32'h0, 1, 121);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; size_i = SZ_WORD; unsigned_i = 1'b0; addr_i = 32'h1E; data_i = 32'hA1B2C3D4;
        @(posedge clk);
        #1 req_i = 1'b0;
        #1 rst_i = 1'b0;
        #1;
        check("beat2_rst_ready",  122, 64'(ready_o),  64'd1);
        check("beat2_rst_rvalid", 122, 64'(rvalid_o), 64'd0);
        check("beat2_rst_data",   122, 64'(data_o),   64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("beat2_no_rvalid", 123 + c, 64'(rvalid_o), 64'd0);
        end
        issue(1'b0, SZ_WORD, 1'b1, 32'h1C, 32'h0, 1'b0, 32'hC3D4FFFF, 1, 126);
        issue(1'b0, SZ_WORD, 1'b1, 32'h20, 32'h0, 1'b0, 32'hFFFFFFFF, 1, 127);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 200, 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
